fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory read at a time, fills the IF/ID register,
// and parks a response in a skid slot when decode stalls. Redirects can arrive while a read is outstanding.
module fetch_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] pred_npc,
  input  logic                 pred_hit,
  output logic                 i_readM,
  input  logic                 i_ready,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic [WORD_SIZE-1:0] if_id_instr,
  output logic [WORD_SIZE-1:0] if_id_pred_npc,
  output logic                 if_id_pred_taken
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t               r_state, w_next_state;
  logic [WORD_SIZE-1:0] r_pc, r_pending;
  logic [WORD_SIZE-1:0] r_skid_pc, r_skid_instr, r_skid_npc;
  logic                 r_skid_taken;
  logic                 r_if_id_valid, r_if_id_taken;
  logic [WORD_SIZE-1:0] r_if_id_pc, r_if_id_instr, r_if_id_npc;

  logic [WORD_SIZE-1:0] w_pc_inc, w_pc_next;
  logic                 w_pred_taken, w_accept, w_read;
  logic                 w_load_mem, w_load_skid, w_capture_skid, w_pending_load;

  assign w_pc_inc     = r_pc + WORD_SIZE'(1);
  assign w_pred_taken = pred_hit && (pred_npc != w_pc_inc);
  assign w_accept     = !stall || !r_if_id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  w_next_state = FETCH;
      FETCH: begin
        if (redirect)                  w_next_state = i_ready ? FETCH : DRAIN;
        else if (i_ready && !w_accept) w_next_state = HOLD;
      end
      HOLD:  if (redirect || !stall) w_next_state = FETCH;
      // A redirect coinciding with the drained response retires it and restarts at redirect_pc.
      DRAIN: if (i_ready) w_next_state = FETCH;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_read         = (r_state == FETCH) || (r_state == DRAIN);
    i_readM        = w_read;
    w_load_mem     = (r_state == FETCH) && i_ready && !redirect && w_accept;
    w_capture_skid = (r_state == FETCH) && i_ready && !redirect && !w_accept;
    w_load_skid    = (r_state == HOLD) && !stall && !redirect;
    w_pending_load = redirect && w_read && !i_ready;
    w_pc_next      = r_pc;
    if (redirect) begin
      // While a read is still in flight the pc must stay put; the target waits in r_pending.
      if (i_ready || !w_read) w_pc_next = redirect_pc;
    end else if (w_load_mem) begin
      w_pc_next = pred_npc;
    end else if (w_load_skid) begin
      w_pc_next = r_skid_npc;
    end else if ((r_state == DRAIN) && i_ready) begin
      w_pc_next = r_pending;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_pending     <= '0;
      r_skid_pc     <= '0;
      r_skid_instr  <= '0;
      r_skid_npc    <= '0;
      r_skid_taken  <= 1'b0;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
      r_if_id_npc   <= '0;
      r_if_id_taken <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_pending_load) r_pending <= redirect_pc;
      if (w_capture_skid) begin
        r_skid_pc    <= r_pc;
        r_skid_instr <= i_data;
        r_skid_npc   <= pred_npc;
        r_skid_taken <= w_pred_taken;
      end
      if (redirect) begin
        r_if_id_valid <= 1'b0;
      end else if (w_load_mem) begin
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= r_pc;
        r_if_id_instr <= i_data;
        r_if_id_npc   <= pred_npc;
        r_if_id_taken <= w_pred_taken;
      end else if (w_load_skid) begin
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= r_skid_pc;
        r_if_id_instr <= r_skid_instr;
        r_if_id_npc   <= r_skid_npc;
        r_if_id_taken <= r_skid_taken;
      end else if (!stall) begin
        r_if_id_valid <= 1'b0;
      end
    end
  end

  assign pc               = r_pc;
  assign if_id_valid      = r_if_id_valid;
  assign if_id_pc         = r_if_id_pc;
  assign if_id_instr      = r_if_id_instr;
  assign if_id_pred_npc   = r_if_id_npc;
  assign if_id_pred_taken = r_if_id_taken;

endmodule
